// File: rtl/debug_dump_tx.sv
// Debug-snapshot transmitter: captures the core's debug buses on a halt edge or host request
// and streams them as a framed byte sequence (0xA5, 184 payload bytes, XOR checksum).
module debug_dump_tx (
    input  logic          clk,
    input  logic          reset,
    input  logic [1023:0] du_reg,
    input  logic [255:0]  du_mem,
    input  logic [63:0]   du_if_id,
    input  logic [125:0]  du_id_ex,
    input  logic          du_halt,
    input  logic          start,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    // state | meaning
    // IDLE  | waiting for start or halt edge
    // HDR   | presenting header byte 0xA5
    // PAY   | presenting payload bytes 0..183, LS byte of snapshot first
    // CHK   | presenting XOR checksum of payload
    // DONE  | one-cycle done pulse, triggers ignored
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] HEADER   = 8'hA5;
    localparam logic [7:0] LAST_PAY = 8'd183;

    state_t         state;
    logic [1471:0]  snap;
    logic [7:0]     cnt;
    logic [7:0]     csum;
    logic           halt_q;
    logic           trigger;

    assign trigger = start | (du_halt & ~halt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            halt_q   <= 1'b0;
            cnt      <= 8'd0;
            csum     <= 8'd0;
        end else begin
            halt_q <= du_halt;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        snap     <= {du_mem, du_reg, 2'b00, du_id_ex, du_if_id};
                        csum     <= 8'd0;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        cnt     <= 8'd0;
                        tx_data <= snap[7:0];
                        state   <= PAY;
                    end
                end
                PAY: begin
                    if (tx_ready) begin
                        snap <= snap >> 8;
                        csum <= csum ^ tx_data;
                        cnt  <= cnt + 8'd1;
                        // tx_data mirrors snap[7:0] here, so the final checksum folds in the byte just accepted
                        if (cnt == LAST_PAY) begin
                            tx_data <= csum ^ tx_data;
                            state   <= CHK;
                        end else begin
                            tx_data <= snap[15:8];
                        end
                    end
                end
                CHK: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: stimulus pushes expected frames, a negedge monitor
// pops and compares every accepted byte and checks hold-while-stalled behaviour.
module tb_debug_dump_tx;

    logic          clk = 1'b0;
    logic          reset;
    logic [1023:0] du_reg;
    logic [255:0]  du_mem;
    logic [63:0]   du_if_id;
    logic [125:0]  du_id_ex;
    logic          du_halt;
    logic          start;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;

    debug_dump_tx dut (
        .clk(clk), .reset(reset), .du_reg(du_reg), .du_mem(du_mem), .du_if_id(du_if_id),
        .du_id_ex(du_id_ex), .du_halt(du_halt), .start(start), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         trig_edge = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_frame[$];
    bit         rnd_ready = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: samples mid-cycle, so the values seen are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                rx_cnt++;
                rx_frame.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_width", 32'(prev_done), 32'd0);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic push_frame();
        logic [1471:0] s;
        logic [7:0]    cs;
        s  = {du_mem, du_reg, 2'b00, du_id_ex, du_if_id};
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 184; i++) begin
            exp_q.push_back(s[i*8 +: 8]);
            cs ^= s[i*8 +: 8];
        end
        exp_q.push_back(cs);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 32; i++) du_reg[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) du_mem[i*32 +: 32] = $urandom;
        du_if_id = {$urandom, $urandom};
        du_id_ex = {30'($urandom), $urandom, $urandom, $urandom};
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start     = 1'b1;
        trig_edge = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 3000 && rx_cnt < n; i++) @(posedge clk);
        if (rx_cnt < n) chk("wait_rx_timeout", 32'(rx_cnt), 32'(n));
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 3000 && done_cnt == prev; i++) @(posedge clk);
        chk("done_seen", 32'(done_cnt), 32'(prev + 1));
    endtask

    int d0;

    initial begin
        reset = 1'b1; start = 1'b0; du_halt = 1'b0;
        du_reg = '0; du_mem = '0; du_if_id = '0; du_id_ex = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);

        // Directed frame with hand-known content
        for (int i = 0; i < 32; i++) du_reg[i*32 +: 32] = 32'(i);
        du_if_id = 64'h00000000_00000004;
        push_frame();
        rx_frame.delete();
        d0 = done_cnt;
        pulse_start();
        chk("busy_after_trig", 32'(busy), 32'd1);
        chk("hdr_data", 32'(tx_data), 32'hA5);
        wait_done(d0);
        chk("done_time", 32'(done_cyc), 32'(trig_edge + 186));
        chk("frame_len", 32'(rx_frame.size()), 32'd186);
        if (rx_frame.size() == 186) begin
            chk("ifid_byte0", 32'(rx_frame[1]), 32'h04);
            chk("r1_byte", 32'(rx_frame[29]), 32'h01);
            chk("r31_byte", 32'(rx_frame[1 + 24 + 124]), 32'h1F);
            chk("csum_byte", 32'(rx_frame[185]), 32'h04);
        end
        chk("q_empty1", 32'(exp_q.size()), 32'd0);

        // Random snapshot with random back-pressure
        rnd_ready = 1'b1;
        rand_inputs();
        push_frame();
        rx_frame.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
        chk("frame_len2", 32'(rx_frame.size()), 32'd186);
        chk("q_empty2", 32'(exp_q.size()), 32'd0);

        // Halt edge held high: one frame only
        rnd_ready = 1'b0;
        rand_inputs();
        push_frame();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        du_halt = 1'b1;
        wait_done(d0);
        repeat (400) @(posedge clk);
        chk("halt_one_frame", 32'(done_cnt), 32'(d0 + 1));
        chk("q_empty3", 32'(exp_q.size()), 32'd0);
        #1;
        du_halt = 1'b0;
        repeat (3) @(posedge clk);

        // Triggers during a frame are ignored
        rand_inputs();
        push_frame();
        d0 = done_cnt;
        rx_cnt = 0;
        pulse_start();
        wait_rx(11);
        #1; start = 1'b1;
        @(posedge clk);
        #1; start = 1'b0;
        wait_rx(51);
        #1; du_halt = 1'b1;
        wait_rx(101);
        #1; start = 1'b1;
        @(posedge clk);
        #1; start = 1'b0;
        wait_done(d0);
        repeat (300) @(posedge clk);
        chk("busy_trig_ignored", 32'(done_cnt), 32'(d0 + 1));
        chk("q_empty4", 32'(exp_q.size()), 32'd0);
        #1;
        du_halt = 1'b0;
        repeat (3) @(posedge clk);

        // Reset mid-frame, then a clean frame
        rand_inputs();
        push_frame();
        d0 = done_cnt;
        rx_cnt = 0;
        pulse_start();
        wait_rx(61);
        #1; reset = 1'b1;
        @(posedge clk);
        #1; reset = 1'b0;
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        rnd_ready = 1'b1;
        rand_inputs();
        push_frame();
        rx_frame.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
        chk("frame_len5", 32'(rx_frame.size()), 32'd186);
        chk("q_empty5", 32'(exp_q.size()), 32'd0);

        // Inputs scrambled every cycle after capture
        rnd_ready = 1'b0;
        rand_inputs();
        push_frame();
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            rand_inputs();
            @(posedge clk);
            #1;
        end
        chk("scramble_done", 32'(done_cnt), 32'(d0 + 1));
        chk("q_empty6", 32'(exp_q.size()), 32'd0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
